// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants and the fetch-stage state type
// Provides XLEN, the canonical NOP encoding, the default reset PC and fetch_state_t.
package rv32_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    typedef enum logic [0:0] {S_RUN = 1'b0, S_FAULT = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_if_id_reg.sv
// fetch_if_id_reg: IF/ID pipeline register with load, flush and drop controls
// Ports: clk, rst; load (capture instr_in/pc_in/pc_plus4_in, set valid),
// flush (clear valid, force NOP), drop (clear valid only);
// valid/instr/pc/pc_plus4 are the registered slot contents.
module fetch_if_id_reg
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            drop,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            instr    <= NOP;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= instr_in;
            pc       <= pc_in;
            pc_plus4 <= pc_plus4_in;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with redirect, IF/ID handshake and fetch faults
// Ports: clk, rst (sync, active-high); imem_addr/imem_instr to a combinational-read memory;
// redirect_valid/redirect_pc from execute; id_ready from decode;
// id_valid/id_instr/id_pc/id_pc_plus4 toward decode; fetch_fault sticky halt flag.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR       = 32'h0000_0013,
    parameter int          IMEM_DEPTH_LOG2 = 22
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault
);
    fetch_state_t state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic run, free, misalign, oor, fault_now, flush, load;

    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign run       = state_q == S_RUN;
    assign free      = !id_valid || id_ready;
    assign misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // Any address bit above the word-addressable range marks the fetch out of range.
    assign oor       = (pc_q >> (IMEM_DEPTH_LOG2 + 2)) != 32'd0;
    assign fault_now = run && (misalign || (!redirect_valid && free && oor));
    assign flush     = run && redirect_valid && !misalign;
    assign load      = run && !redirect_valid && free && !oor;
    assign fetch_fault = state_q == S_FAULT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= fault_now ? S_FAULT : state_q;
            pc_q    <= (run && redirect_valid) ? redirect_pc : load ? pc_plus4 : pc_q;
        end
    end

    fetch_if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .flush       (flush),
        .drop        (fault_now),
        .instr_in    (imem_instr),
        .pc_in       (pc_q),
        .pc_plus4_in (pc_plus4),
        .valid       (id_valid),
        .instr       (id_instr),
        .pc          (id_pc),
        .pc_plus4    (id_pc_plus4)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] LIMIT = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr, imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_ready = 1'b1;
    logic        id_valid, fetch_fault;
    logic [31:0] id_instr, id_pc, id_pc_plus4;

    logic [31:0] mem [64];
    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc = 32'd0, m_instr = NOP, m_idpc = 32'd0, m_p4 = 32'd0;
    logic        m_valid = 1'b0, m_fault = 1'b0;

    always #5 clk = ~clk;
    assign imem_instr = mem[imem_addr[7:2]];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_fault    (fetch_fault)
    );

    task automatic model();
        if (rst) begin
            m_pc = 32'd0; m_fault = 1'b0; m_valid = 1'b0; m_instr = NOP; m_idpc = 32'd0; m_p4 = 32'd0;
        end else if (!m_fault) begin
            if (redirect_valid && redirect_pc % 4 != 0) begin
                m_fault = 1'b1; m_valid = 1'b0; m_pc = redirect_pc;
            end else if (redirect_valid) begin
                m_pc = redirect_pc; m_valid = 1'b0; m_instr = NOP;
            end else if (!m_valid || id_ready) begin
                if (m_pc >= LIMIT) begin
                    m_fault = 1'b1; m_valid = 1'b0;
                end else begin
                    m_instr = mem[(m_pc / 4) % 64]; m_idpc = m_pc; m_p4 = m_pc + 4;
                    m_valid = 1'b1; m_pc = m_pc + 4;
                end
            end
        end
    endtask

    task automatic cyc();
        model();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        n_cmp++; if (id_instr !== NOP) begin n_err++; $display("FAIL reset_instr: got %h want %h", id_instr, NOP); end
        n_cmp++; if (imem_addr !== 32'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
        n_cmp++; if (id_pc !== 32'd0 || id_pc_plus4 !== 32'd0) begin n_err++; $display("FAIL reset_pc: got %h/%h want 0/0", id_pc, id_pc_plus4); end
        rst = 1'b0;
        cyc();
        n_cmp++; if (id_valid !== 1'b1 || id_instr !== 32'h00500113) begin n_err++; $display("FAIL first_fetch: got %b %h want 1 00500113", id_valid, id_instr); end
        n_cmp++; if (id_pc !== 32'd0 || id_pc_plus4 !== 32'd4) begin n_err++; $display("FAIL first_pc: got %h/%h want 0/4", id_pc, id_pc_plus4); end
        cyc();
        n_cmp++; if (id_instr !== 32'h00212223 || id_pc !== 32'd4) begin n_err++; $display("FAIL second_fetch: got %h@%h want 00212223@4", id_instr, id_pc); end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'd4 || id_instr !== 32'h00212223) begin n_err++; $display("FAIL stall_hold: got %b %h@%h want 1 00212223@4", id_valid, id_instr, id_pc); end
            n_cmp++; if (imem_addr !== 32'd8) begin n_err++; $display("FAIL stall_addr: got %h want 8", imem_addr); end
        end
        id_ready = 1'b1;
        cyc();
        n_cmp++; if (id_pc !== 32'd8 || id_instr !== 32'h00412183) begin n_err++; $display("FAIL stall_release: got %h@%h want 00412183@8", id_instr, id_pc); end
    endtask

    task automatic test_redirect();
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        cyc();
        n_cmp++; if (id_valid !== 1'b0 || id_instr !== NOP) begin n_err++; $display("FAIL flush_slot: got %b %h want 0 %h", id_valid, id_instr, NOP); end
        n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL flush_addr: got %h want 40", imem_addr); end
        redirect_valid = 1'b0;
        cyc();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== mem[16]) begin n_err++; $display("FAIL redirect_fetch: got %b %h@%h want 1 %h@40", id_valid, id_instr, id_pc, mem[16]); end
        n_cmp++; if (id_pc_plus4 !== 32'h44) begin n_err++; $display("FAIL redirect_p4: got %h want 44", id_pc_plus4); end
        id_ready = 1'b1;
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        cyc();
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (fetch_fault !== 1'b1 || id_valid !== 1'b0) begin n_err++; $display("FAIL misalign_fault: got fault=%b valid=%b want 1 0", fetch_fault, id_valid); end
            n_cmp++; if (imem_addr !== 32'h42) begin n_err++; $display("FAIL misalign_addr: got %h want 42", imem_addr); end
            redirect_pc = 32'h80; id_ready = 1'($urandom);
            cyc();
        end
        redirect_valid = 1'b0; id_ready = 1'b1; rst = 1'b1;
        cyc();
        n_cmp++; if (imem_addr !== 32'd0 || fetch_fault !== 1'b0) begin n_err++; $display("FAIL misalign_recover: got %h fault=%b want 0 0", imem_addr, fetch_fault); end
        rst = 1'b0;
    endtask

    task automatic test_range();
        redirect_valid = 1'b1; redirect_pc = LIMIT;
        cyc();
        n_cmp++; if (imem_addr !== LIMIT || fetch_fault !== 1'b0) begin n_err++; $display("FAIL range_addr: got %h fault=%b want %h 0", imem_addr, fetch_fault, LIMIT); end
        redirect_valid = 1'b0;
        cyc();
        n_cmp++; if (fetch_fault !== 1'b1 || id_valid !== 1'b0 || imem_addr !== LIMIT) begin n_err++; $display("FAIL range_fault: got fault=%b valid=%b addr=%h want 1 0 %h", fetch_fault, id_valid, imem_addr, LIMIT); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset_redirect();
        cyc();
        cyc();
        id_ready = 1'b0;
        cyc();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        cyc();
        n_cmp++; if (imem_addr !== 32'd0 || id_valid !== 1'b0 || fetch_fault !== 1'b0) begin n_err++; $display("FAIL rst_vs_redirect: got %h valid=%b fault=%b want 0 0 0", imem_addr, id_valid, fetch_fault); end
        rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
        cyc();
        n_cmp++; if (id_pc !== 32'd0 || id_instr !== 32'h00500113) begin n_err++; $display("FAIL rst_restart: got %h@%h want 00500113@0", id_instr, id_pc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(99) == 0);
            id_ready = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(9) == 0);
            case ($urandom_range(15))
                0: redirect_pc = {$urandom_range(255), 2'b00} | 32'h1 << $urandom_range(1);
                1: redirect_pc = 32'h00FF_FFF8;
                2: redirect_pc = $urandom & 32'hFFFF_FFFC;
                default: redirect_pc = {22'd0, 8'($urandom), 2'b00};
            endcase
            cyc();
            n_cmp++; if (imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", i, imem_addr, m_pc); end
            n_cmp++; if (id_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", i, id_valid, m_valid); end
            n_cmp++; if (id_instr !== m_instr) begin n_err++; $display("FAIL rnd_instr@%0d: got %h want %h", i, id_instr, m_instr); end
            n_cmp++; if (id_pc !== m_idpc || id_pc_plus4 !== m_p4) begin n_err++; $display("FAIL rnd_pc@%0d: got %h/%h want %h/%h", i, id_pc, id_pc_plus4, m_idpc, m_p4); end
            n_cmp++; if (fetch_fault !== m_fault) begin n_err++; $display("FAIL rnd_fault@%0d: got %b want %b", i, fetch_fault, m_fault); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h00500113;
        mem[1] = 32'h00212223;
        mem[2] = 32'h00412183;
        mem[3] = 32'h00000013;
        test_reset();
        test_stall();
        test_redirect();
        test_misaligned();
        test_range();
        test_reset_redirect();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
